// File: rtl/vram_arbiter.sv
// Round-robin arbiter sharing one VRAM port among CORE_NUM cores, with locked bursts.
// Optional: define VRAM_ARB_CORE0_PRIO_EN to give core 0 priority outside lock bursts.
module vram_arbiter #(
  parameter int CORE_NUM  = 4,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int MAX_BURST = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [CORE_NUM-1:0]        core_en,
  input  logic [CORE_NUM-1:0]        core_req,
  input  logic [CORE_NUM-1:0]        core_we,
  input  logic [CORE_NUM-1:0]        core_lock,
  input  logic [CORE_NUM*ADDR_W-1:0] core_addr,
  input  logic [CORE_NUM*DATA_W-1:0] core_wdata,
  output logic [CORE_NUM-1:0]        core_ack,
  output logic [DATA_W-1:0]          core_rdata,
  output logic                       mem_en,
  output logic                       mem_we,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  input  logic [DATA_W-1:0]          mem_rdata,
  output logic                       busy,
  output logic [2:0]                 grant_id
);

  localparam int IDX_W = (CORE_NUM > 1) ? $clog2(CORE_NUM) : 1;
  localparam logic [3:0] BURST_LIM = 4'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [CORE_NUM-1:0]   r_ack, w_ack_nxt;
  logic [DATA_W-1:0]     r_rdata, w_rdata_nxt;
  logic                  r_mem_en, w_mem_en_nxt;
  logic                  r_mem_we, w_mem_we_nxt;
  logic [ADDR_W-1:0]     r_mem_addr, w_mem_addr_nxt;
  logic [DATA_W-1:0]     r_mem_wdata, w_mem_wdata_nxt;
  logic                  r_busy;
  logic [2:0]            r_grant_id;
  logic [IDX_W-1:0]      r_grant, w_grant_nxt;
  logic [IDX_W-1:0]      r_ptr, w_ptr_nxt;
  logic [3:0]            r_burst, w_burst_nxt, w_burst_ack;

  logic [CORE_NUM-1:0]   w_elig;
  logic                  w_lock_hit;
  logic [IDX_W-1:0]      w_rr_win, w_win;
  logic                  w_rr_vld, w_win_vld;

  assign w_elig     = core_req & core_en;
  assign w_lock_hit = (r_burst != 4'd0) && w_elig[r_grant];
  // Burst bookkeeping applied in the cycle the ack is visible to the core
  assign w_burst_ack = (core_lock[r_grant] && (r_burst < BURST_LIM)) ? (r_burst + 4'd1) : 4'd0;

  // Descending scan so the nearest eligible core after the pointer wins
  always_comb begin
    w_rr_win = r_ptr;
    w_rr_vld = 1'b0;
    for (int k = CORE_NUM; k >= 1; k--) begin
      if (w_elig[IDX_W'((int'(r_ptr) + k) % CORE_NUM)]) begin
        w_rr_win = IDX_W'((int'(r_ptr) + k) % CORE_NUM);
        w_rr_vld = 1'b1;
      end
    end
  end

  always_comb begin
    w_win     = '0;
    w_win_vld = 1'b0;
    if (w_lock_hit) begin
      w_win     = r_grant;
      w_win_vld = 1'b1;
    end
`ifdef VRAM_ARB_CORE0_PRIO_EN
    else if (w_elig[0]) begin
      w_win     = '0;
      w_win_vld = 1'b1;
    end
`endif
    else begin
      w_win     = w_rr_win;
      w_win_vld = w_rr_vld;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_ack_nxt       = '0;
    w_rdata_nxt     = r_rdata;
    w_mem_en_nxt    = 1'b0;
    w_mem_we_nxt    = r_mem_we;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_grant_nxt     = r_grant;
    w_ptr_nxt       = r_ptr;
    w_burst_nxt     = r_burst;
    case (r_state)
      ST_IDLE: begin
        if (!w_lock_hit) begin
          w_burst_nxt = 4'd0;
        end else begin
          w_burst_nxt = r_burst;
        end
        if (w_win_vld) begin
          w_grant_nxt       = w_win;
          w_ptr_nxt         = w_win;
          w_mem_en_nxt      = 1'b1;
          w_mem_we_nxt      = core_we[w_win];
          w_mem_addr_nxt    = core_addr[w_win*ADDR_W +: ADDR_W];
          w_mem_wdata_nxt   = core_wdata[w_win*DATA_W +: DATA_W];
          w_ack_nxt[w_win]  = core_we[w_win];
          w_state_nxt       = ST_ISSUE;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (r_mem_we) begin
          w_burst_nxt = w_burst_ack;
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        w_rdata_nxt        = mem_rdata;
        w_ack_nxt[r_grant] = 1'b1;
        w_state_nxt        = ST_RESP;
      end
      ST_RESP: begin
        w_burst_nxt = w_burst_ack;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_ack       <= '0;
      r_rdata     <= '0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_busy      <= 1'b0;
      r_grant_id  <= 3'd0;
      r_grant     <= '0;
      r_ptr       <= IDX_W'(CORE_NUM - 1);
      r_burst     <= 4'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_ack       <= w_ack_nxt;
      r_rdata     <= w_rdata_nxt;
      r_mem_en    <= w_mem_en_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_busy      <= (w_state_nxt != ST_IDLE);
      r_grant_id  <= 3'(w_grant_nxt);
      r_grant     <= w_grant_nxt;
      r_ptr       <= w_ptr_nxt;
      r_burst     <= w_burst_nxt;
    end
  end

  assign core_ack   = r_ack;
  assign core_rdata = r_rdata;
  assign mem_en     = r_mem_en;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign busy       = r_busy;
  assign grant_id   = r_grant_id;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed self-checking bench for vram_arbiter (default build, CORE_NUM=4, MAX_BURST=4).
module tb_vram_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  core_en;
  logic [3:0]  core_req;
  logic [3:0]  core_we;
  logic [3:0]  core_lock;
  logic [63:0] core_addr;
  logic [63:0] core_wdata;
  logic [3:0]  core_ack;
  logic [15:0] core_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        busy;
  logic [2:0]  grant_id;

  int n_cmp;
  int n_err;

  vram_arbiter #(
    .CORE_NUM(4), .ADDR_W(16), .DATA_W(16), .MAX_BURST(4)
  ) dut (
    .clk(clk), .rst(rst),
    .core_en(core_en), .core_req(core_req), .core_we(core_we), .core_lock(core_lock),
    .core_addr(core_addr), .core_wdata(core_wdata),
    .core_ack(core_ack), .core_rdata(core_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .grant_id(grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_core(input int i, input logic req, input logic we, input logic lk,
                          input logic [15:0] addr, input logic [15:0] wd);
    core_req[i]             = req;
    core_we[i]              = we;
    core_lock[i]            = lk;
    core_addr[i*16 +: 16]   = addr;
    core_wdata[i*16 +: 16]  = wd;
  endtask

  initial begin
    int ord_a [6];
    int ord_b [6];
    ord_a = '{2, 3, 0, 1, 2, 3};
    ord_b = '{1, 3, 0, 1, 3, 0};
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    core_en = 4'b1111;
    core_req = 4'b0000;
    core_we = 4'b0000;
    core_lock = 4'b0000;
    core_addr = 64'd0;
    core_wdata = 64'd0;
    mem_rdata = 16'd0;
    tick();
    tick();
    chk("rst_ack", 32'(core_ack), 32'h0);
    chk("rst_rdata", 32'(core_rdata), 32'h0);
    chk("rst_mem_en", 32'(mem_en), 32'h0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_grant", 32'(grant_id), 32'h0);
    rst = 1'b0;

    // Single write from core 2
    set_core(2, 1'b1, 1'b1, 1'b0, 16'h0040, 16'hBEEF);
    tick();
    chk("wr_mem_en", 32'(mem_en), 32'h1);
    chk("wr_mem_we", 32'(mem_we), 32'h1);
    chk("wr_addr", 32'(mem_addr), 32'h0040);
    chk("wr_data", 32'(mem_wdata), 32'hBEEF);
    chk("wr_ack", 32'(core_ack), 32'h4);
    chk("wr_busy", 32'(busy), 32'h1);
    chk("wr_grant", 32'(grant_id), 32'h2);
    core_req[2] = 1'b0;
    tick();
    chk("wr_mem_en_off", 32'(mem_en), 32'h0);
    chk("wr_ack_off", 32'(core_ack), 32'h0);
    chk("wr_busy_off", 32'(busy), 32'h0);

    // Read from core 1, memory returns 0x1234
    set_core(1, 1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000);
    tick();
    chk("rd_mem_en", 32'(mem_en), 32'h1);
    chk("rd_mem_we", 32'(mem_we), 32'h0);
    chk("rd_addr", 32'(mem_addr), 32'h0010);
    chk("rd_ack_issue", 32'(core_ack), 32'h0);
    chk("rd_grant", 32'(grant_id), 32'h1);
    tick();
    mem_rdata = 16'h1234;
    chk("rd_mem_en_wait", 32'(mem_en), 32'h0);
    chk("rd_ack_wait", 32'(core_ack), 32'h0);
    tick();
    mem_rdata = 16'h0000;
    chk("rd_ack", 32'(core_ack), 32'h2);
    chk("rd_data", 32'(core_rdata), 32'h1234);
    core_req[1] = 1'b0;
    tick();
    chk("rd_ack_off", 32'(core_ack), 32'h0);
    chk("rd_busy_off", 32'(busy), 32'h0);

    // All four cores writing continuously; pointer sits at 1
    for (int i = 0; i < 4; i++) set_core(i, 1'b1, 1'b1, 1'b0, 16'h0100 + 16'(i), 16'hA0A0 + 16'(i));
    for (int g = 0; g < 6; g++) begin
      tick();
      chk("rr_ack", 32'(core_ack), 32'(4'b0001 << ord_a[g]));
      chk("rr_mem_en", 32'(mem_en), 32'h1);
      chk("rr_wdata", 32'(mem_wdata), 32'hA0A0 + 32'(ord_a[g]));
      chk("rr_addr", 32'(mem_addr), 32'h0100 + 32'(ord_a[g]));
      tick();
      chk("rr_gap", 32'(core_ack), 32'h0);
    end
    core_req = 4'b0000;

    // Locked burst from core 3 with core 0 waiting
    set_core(3, 1'b1, 1'b1, 1'b1, 16'h0300, 16'h3333);
    for (int g = 0; g < 4; g++) begin
      tick();
      chk("lock_ack", 32'(core_ack), 32'h8);
      set_core(0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0C0C);
      tick();
      chk("lock_gap", 32'(core_ack), 32'h0);
    end
    tick();
    chk("lock_rotate", 32'(core_ack), 32'h1);
    chk("lock_rotate_gid", 32'(grant_id), 32'h0);
    core_req = 4'b0000;
    core_lock = 4'b0000;
    tick();

    // Core 2 disabled, everyone requesting; pointer sits at 0
    core_en = 4'b1011;
    for (int i = 0; i < 4; i++) set_core(i, 1'b1, 1'b1, 1'b0, 16'h0200 + 16'(i), 16'hD0D0 + 16'(i));
    for (int g = 0; g < 6; g++) begin
      tick();
      chk("en_ack", 32'(core_ack), 32'(4'b0001 << ord_b[g]));
      chk("en_wdata", 32'(mem_wdata), 32'hD0D0 + 32'(ord_b[g]));
      tick();
      chk("en_gap", 32'(core_ack), 32'h0);
    end
    core_req = 4'b0000;
    core_en = 4'b1111;

    // Reset during WAIT of a read from core 2
    set_core(2, 1'b1, 1'b0, 1'b0, 16'h0020, 16'h0000);
    tick();
    chk("rr_rd_mem_en", 32'(mem_en), 32'h1);
    chk("rr_rd_grant", 32'(grant_id), 32'h2);
    tick();
    mem_rdata = 16'h5555;
    rst = 1'b1;
    #1;
    chk("arst_ack", 32'(core_ack), 32'h0);
    chk("arst_busy", 32'(busy), 32'h0);
    chk("arst_grant", 32'(grant_id), 32'h0);
    chk("arst_mem_addr", 32'(mem_addr), 32'h0);
    chk("arst_rdata", 32'(core_rdata), 32'h0);
    tick();
    chk("arst_ack_hold", 32'(core_ack), 32'h0);
    rst = 1'b0;
    mem_rdata = 16'h0000;
    core_req = 4'b0000;
    set_core(0, 1'b1, 1'b1, 1'b0, 16'h0007, 16'h7777);
    set_core(3, 1'b1, 1'b1, 1'b0, 16'h0008, 16'h8888);
    tick();
    chk("post_rst_ack", 32'(core_ack), 32'h1);
    chk("post_rst_grant", 32'(grant_id), 32'h0);
    chk("post_rst_wdata", 32'(mem_wdata), 32'h7777);
    core_req = 4'b0000;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
